// File: rtl/dual_countdown_timer.sv
// Two-channel down-counter with one-cycle expiry pulses; DCT_AUTORELOAD_EN turns expiry into a periodic reload.
// One-cycle latency from inputs to registered outputs; no backpressure, one channel updated per cycle.
module dual_countdown_timer #(
    parameter int WIDTH    = 64,
    parameter int PRESCALE = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Slt,
    input  logic             En,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    output logic [WIDTH-1:0] Output0,
    output logic [WIDTH-1:0] Output1,
    output logic             Expire0,
    output logic             Expire1,
    output logic             Running0,
    output logic             Running1
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    logic [WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [WIDTH-1:0] rld0_q, rld0_d, rld1_q, rld1_d;
    logic [PW-1:0]    pre_q, pre_d;
    state_t           st0_q, st0_d, st1_q, st1_d;
    logic             exp0_q, exp0_d, exp1_q, exp1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        rld0_d = rld0_q;
        rld1_d = rld1_q;
        pre_d  = pre_q;
        st0_d  = st0_q;
        st1_d  = st1_q;
        exp0_d = 1'b0;
        exp1_d = 1'b0;
        if (Load) begin
            // A load overrides any decrement, so a coinciding expiry is swallowed.
            if (!Slt) begin
                cnt0_d = LoadValue;
                rld0_d = LoadValue;
                st0_d  = (LoadValue != '0) ? RUN : IDLE;
            end else begin
                cnt1_d = LoadValue;
                rld1_d = LoadValue;
                st1_d  = (LoadValue != '0) ? RUN : IDLE;
                pre_d  = '0;
            end
        end else if (En) begin
            if (!Slt && st0_q == RUN) begin
                if (cnt0_q == ONE) begin
                    exp0_d = 1'b1;
`ifdef DCT_AUTORELOAD_EN
                    cnt0_d = rld0_q;
`else
                    cnt0_d = '0;
                    st0_d  = IDLE;
`endif
                end else begin
                    cnt0_d = cnt0_q - ONE;
                end
            end else if (Slt && st1_q == RUN) begin
                if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    if (cnt1_q == ONE) begin
                        exp1_d = 1'b1;
`ifdef DCT_AUTORELOAD_EN
                        cnt1_d = rld1_q;
`else
                        cnt1_d = '0;
                        st1_d  = IDLE;
`endif
                    end else begin
                        cnt1_d = cnt1_q - ONE;
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
            rld0_q <= '0;
            rld1_q <= '0;
            pre_q  <= '0;
            st0_q  <= IDLE;
            st1_q  <= IDLE;
            exp0_q <= 1'b0;
            exp1_q <= 1'b0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
            rld0_q <= rld0_d;
            rld1_q <= rld1_d;
            pre_q  <= pre_d;
            st0_q  <= st0_d;
            st1_q  <= st1_d;
            exp0_q <= exp0_d;
            exp1_q <= exp1_d;
        end
    end

    assign Output0  = cnt0_q;
    assign Output1  = cnt1_q;
    assign Expire0  = exp0_q;
    assign Expire1  = exp1_q;
    assign Running0 = (st0_q == RUN);
    assign Running1 = (st1_q == RUN);

endmodule

// File: tb/tb_dual_countdown_timer.sv
// Bench for dual_countdown_timer: directed scenarios plus random traffic against an event-level model.
module tb_dual_countdown_timer;

    localparam int W = 64;
    localparam int P = 4;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         Slt = 1'b0, En = 1'b0, Load = 1'b0;
    logic [W-1:0] LoadValue = '0;
    logic [W-1:0] Output0, Output1;
    logic         Expire0, Expire1, Running0, Running1;

    dual_countdown_timer #(.WIDTH(W), .PRESCALE(P)) dut (
        .Clk(Clk), .Reset(Reset), .Slt(Slt), .En(En), .Load(Load),
        .LoadValue(LoadValue), .Output0(Output0), .Output1(Output1),
        .Expire0(Expire0), .Expire1(Expire1),
        .Running0(Running0), .Running1(Running1)
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: counts, reload values, running flags, pulses, and enabled channel-1 cycles since load.
    logic [W-1:0] m_cnt[2];
    logic [W-1:0] m_rld[2];
    bit           m_run[2];
    bit           m_exp[2];
    int           m_ticks;

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_cnt[c] = '0; m_rld[c] = '0; m_run[c] = 0; m_exp[c] = 0;
        end
        m_ticks = 0;
    endtask

    task automatic model_step(input logic s, input logic e, input logic l, input logic [W-1:0] v);
        int c;
        c = s ? 1 : 0;
        m_exp[0] = 0;
        m_exp[1] = 0;
        if (l) begin
            m_cnt[c] = v;
            m_rld[c] = v;
            m_run[c] = (v != 0);
            if (c == 1) m_ticks = 0;
        end else if (e && m_run[c]) begin
            if (c == 1) m_ticks++;
            if (c == 0 || (m_ticks % P) == 0) begin
                m_cnt[c] = m_cnt[c] - 1;
                if (m_cnt[c] == 0) begin
                    m_exp[c] = 1;
`ifdef DCT_AUTORELOAD_EN
                    m_cnt[c] = m_rld[c];
`else
                    m_run[c] = 0;
`endif
                end
            end
        end
    endtask

    function automatic logic [2*W+3:0] exp_vec();
        return {m_cnt[0], m_cnt[1], m_exp[0], m_exp[1], m_run[0], m_run[1]};
    endfunction

    function automatic logic [2*W+3:0] dut_vec();
        return {Output0, Output1, Expire0, Expire1, Running0, Running1};
    endfunction

    task automatic drive(input logic s, input logic e, input logic l, input logic [W-1:0] v);
        Slt = s; En = e; Load = l; LoadValue = v;
        @(posedge Clk);
        #1;
        model_step(s, e, l, v);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        Slt = 0; En = 0; Load = 0; LoadValue = '0;
        repeat (2) @(posedge Clk);
        #1;
        model_reset();
        vectors++;
        if (dut_vec() !== '0) begin
            miscompares++;
            $display("FAIL reset_state got %h want 0", dut_vec());
        end
        Reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'($urandom_range(0, 1)), 1'b1, 1'b0, {$urandom, $urandom});
            vectors++;
            if (dut_vec() !== '0) begin
                miscompares++;
                $display("FAIL idle_enable cyc %0d got %h want 0", i, dut_vec());
            end
        end
    endtask

    task automatic test_ch0_countdown();
        logic [W-1:0] seq[4];
        seq = '{64'd3, 64'd2, 64'd1, 64'd0};
        drive(1'b0, 1'b0, 1'b1, 64'd3);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) drive(1'b0, 1'b1, 1'b0, '0);
            vectors++;
            if (dut_vec() !== exp_vec() || (i < 4 && Output0 !== seq[i])) begin
                miscompares++;
                $display("FAIL ch0_countdown step %0d got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_ch1_prescale();
        drive(1'b1, 1'b0, 1'b1, 64'd2);
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            vectors++;
            if (dut_vec() !== exp_vec() || Expire1 !== (i == 8)) begin
                miscompares++;
                $display("FAIL ch1_prescale en %0d got %h want %h", i, dut_vec(), exp_vec());
            end
            if (i % 3 == 0) begin
                drive(1'b0, 1'b1, 1'b0, '0);
                vectors++;
                if (dut_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL ch1_hold_on_slt0 en %0d got %h want %h", i, dut_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_load_beats_expire();
        drive(1'b0, 1'b0, 1'b1, 64'd1);
        drive(1'b0, 1'b1, 1'b1, 64'd5);
        vectors++;
        if (dut_vec() !== exp_vec() || Output0 !== 64'd5 || Expire0 !== 1'b0 || Running0 !== 1'b1) begin
            miscompares++;
            $display("FAIL load_beats_expire got %h want %h", dut_vec(), exp_vec());
        end
        drive(1'b0, 1'b0, 1'b1, 64'd0);
        vectors++;
        if (dut_vec() !== exp_vec() || Running0 !== 1'b0) begin
            miscompares++;
            $display("FAIL load_zero_idle got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 1'b1, 64'd8);
        repeat (6) drive(1'b1, 1'b1, 1'b0, '0);
        vectors++;
        if (Output1 !== 64'd7 || dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL pre_reset_ch1 got %h want %h", dut_vec(), exp_vec());
        end
        #3;
        Reset = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (dut_vec() !== '0) begin
            miscompares++;
            $display("FAIL async_reset got %h want 0", dut_vec());
        end
        #3;
        Reset = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 64'd1);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            vectors++;
            if (dut_vec() !== exp_vec() || Expire1 !== (i == 4)) begin
                miscompares++;
                $display("FAIL post_reset_reload en %0d got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

`ifdef DCT_AUTORELOAD_EN
    task automatic test_autoreload();
        drive(1'b0, 1'b0, 1'b1, 64'd2);
        for (int i = 1; i <= 6; i++) begin
            drive(1'b0, 1'b1, 1'b0, '0);
            vectors++;
            if (dut_vec() !== exp_vec() || Expire0 !== (i % 2 == 0) || Running0 !== 1'b1) begin
                miscompares++;
                $display("FAIL autoreload cyc %0d got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] v;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : W'($urandom_range(0, 6));
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0), v);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc %0d got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_ch0_countdown();
        test_ch1_prescale();
        test_load_beats_expire();
        test_async_reset();
`ifdef DCT_AUTORELOAD_EN
        test_autoreload();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
